// File: rtl/operand_fetch.sv
// Operand-read sequencer: time-multiplexes a single combinational register-file read port
// to fetch rs1 and optionally rs2, forwarding same-cycle writebacks, then hands both to execute.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic                  in_need_rs2,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2
);

    typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
    logic                  need_q;
    logic                  accept;
    logic                  wb_live;
    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
    logic                  hold_hit1, hold_hit2;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Writes to x0 never land, so they must never be forwarded or tracked.
    assign wb_live  = wb_valid && (wb_addr != '0);

    // The read port already addresses the operand being captured, so rf_rdata is
    // the stored value; a same-cycle writeback supersedes it.
    always_comb begin
        fwd_rs1 = rf_rdata;
        if (rs1_q == '0)
            fwd_rs1 = '0;
        else if (wb_live && (wb_addr == rs1_q))
            fwd_rs1 = wb_data;

        fwd_rs2 = rf_rdata;
        if (rs2_q == '0)
            fwd_rs2 = '0;
        else if (wb_live && (wb_addr == rs2_q))
            fwd_rs2 = wb_data;
    end

    assign hold_hit1 = wb_live && (wb_addr == rs1_q);
    assign hold_hit2 = wb_live && need_q && (wb_addr == rs2_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = RD1;
            RD1:  state_nxt = need_q ? RD2 : DONE;
            RD2:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            need_q    <= 1'b0;
            rf_raddr  <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs1_q    <= in_rs1;
                        rs2_q    <= in_rs2;
                        need_q   <= in_need_rs2;
                        rf_raddr <= in_rs1;
                    end
                end
                RD1: begin
                    out_op1 <= fwd_rs1;
                    if (need_q) begin
                        rf_raddr <= rs2_q;
                    end else begin
                        out_op2   <= '0;
                        out_valid <= 1'b1;
                    end
                end
                RD2: begin
                    out_op2   <= fwd_rs2;
                    out_valid <= 1'b1;
                    rf_raddr  <= '0;
                end
                DONE: begin
                    // Consumption takes priority: execute has already sampled the held value.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end else begin
                        if (hold_hit1) out_op1 <= wb_data;
                        if (hold_hit2) out_op2 <= wb_data;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a behavioural register file feeds rf_rdata,
// expected operands are queued when each request is driven and compared at out_valid.
module tb_operand_fetch;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_need_rs2;
    logic [AW-1:0] in_rs1, in_rs2, rf_raddr, wb_addr;
    logic [DW-1:0] rf_rdata, wb_data, out_op1, out_op2;
    logic          wb_valid, out_valid, out_ready;

    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          need;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Register file model: deliberately stores writes to x0 so the DUT must ignore it.
    logic [DW-1:0] regs [32];
    assign rf_rdata = regs[rf_raddr];
    always @(posedge clk) if (wb_valid) regs[wb_addr] <= wb_data;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_need_rs2(in_need_rs2),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2)
    );

    function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (wb_valid && wb_addr == a) return wb_data;
        return regs[a];
    endfunction

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // Drives one request from IDLE through RD1 (and RD2), leaving the DUT in DONE.
    task automatic do_req(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic need,
                          input logic wb1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic wb2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        exp_t e;
        e.rs1 = rs1; e.rs2 = rs2; e.need = need;
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_need_rs2 = need;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_idle: got %b expected 1", in_ready); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (rf_raddr !== rs1) begin n_fail++; $display("FAIL rf_raddr_rd1: got %0d expected %0d", rf_raddr, rs1); end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd1_flags: got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        wb_valid = wb1; wb_addr = a1; wb_data = d1;
        e.op1 = model_fwd(rs1);
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0;
        if (need) begin
            n_checks++;
            if (rf_raddr !== rs2) begin n_fail++; $display("FAIL rf_raddr_rd2: got %0d expected %0d", rf_raddr, rs2); end
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd2_out_valid: got %b expected 0", out_valid); end
            wb_valid = wb2; wb_addr = a2; wb_data = d2;
            e.op2 = model_fwd(rs2);
            @(posedge clk); @(negedge clk);
            wb_valid = 1'b0;
        end else begin
            e.op2 = '0;
        end
        sb.push_back(e);
    endtask

    // Holds DONE for 'hold' cycles (optional writeback in the first), then consumes.
    task automatic finish_req(input string name, input int hold,
                              input logic wbh, input logic [AW-1:0] ah, input logic [DW-1:0] dh,
                              input logic wbc, input logic [AW-1:0] ac, input logic [DW-1:0] dc);
        exp_t e;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL %s_hold: got out_valid=%b in_ready=%b expected 1 0", name, out_valid, in_ready);
            end
            if (i == 0 && wbh) begin
                wb_valid = 1'b1; wb_addr = ah; wb_data = dh;
                e = sb[0];
                if (ah != '0 && ah == e.rs1) e.op1 = dh;
                if (ah != '0 && e.need && ah == e.rs2) e.op2 = dh;
                sb[0] = e;
            end
            @(posedge clk); @(negedge clk);
            wb_valid = 1'b0;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b expected 1", name, out_valid); end
        if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL %s_sb: got empty scoreboard expected entry", name);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (out_op1 !== e.op1) begin n_fail++; $display("FAIL %s_op1: got %h expected %h", name, out_op1, e.op1); end
            n_checks++;
            if (out_op2 !== e.op2) begin n_fail++; $display("FAIL %s_op2: got %h expected %h", name, out_op2, e.op2); end
        end
        // A writeback coinciding with the handshake must not disturb the consumed values.
        out_ready = 1'b1;
        wb_valid = wbc; wb_addr = ac; wb_data = dc;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0; wb_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_release: got out_valid=%b in_ready=%b expected 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || rf_raddr !== '0 || out_op1 !== '0 || out_op2 !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b rdy=%b ra=%0d op1=%h op2=%h expected all 0",
                     out_valid, in_ready, rf_raddr, out_op1, out_op2);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_two_operand();
        do_req(5'd5, 5'd6, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        finish_req("two_op", 0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_single_operand();
        do_req(5'd5, 5'd6, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        finish_req("one_op", 0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_x0();
        do_req(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'h77);
        finish_req("x0", 2, 1'b1, 5'd0, 32'h99, 1'b0, '0, '0);
    endtask

    task automatic test_forward();
        do_req(5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 32'h33, 1'b1, 5'd6, 32'h44);
        finish_req("forward", 0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_hold();
        do_req(5'd5, 5'd6, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        finish_req("hold", 4, 1'b1, 5'd6, 32'h55, 1'b1, 5'd5, 32'h66);
        // The write during the handshake landed in the file and is seen by the next request.
        do_req(5'd5, 5'd7, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        finish_req("after_hs_wb", 0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_same_reg();
        do_req(5'd7, 5'd7, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        finish_req("same_reg", 2, 1'b1, 5'd7, 32'hABCD_0007, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_need_rs2 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_op1 !== '0 || out_op2 !== '0 || rf_raddr !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b op1=%h op2=%h ra=%0d rdy=%b expected all 0",
                     out_valid, out_op1, out_op2, rf_raddr, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset_mid_idle: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
            end
        end
        do_req(5'd5, 5'd6, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        finish_req("post_reset", 0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 24; k++) begin
            do_req(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            finish_req("b2b", $urandom_range(0, 2),
                       1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_need_rs2 = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        test_reset();
        rf_write(5'd0, 32'hDEAD_BEEF);
        for (int r = 1; r < 8; r++) rf_write(AW'(r), 32'h100 * r + 32'h7);
        rf_write(5'd5, 32'h11);
        rf_write(5'd6, 32'h22);
        test_two_operand();
        test_single_operand();
        test_x0();
        test_forward();
        test_hold();
        test_same_reg();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish within 200000 time units");
        $fatal(1);
    end
endmodule
